pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the fixed 8-bit ripple-carry adder used in the arithmetic library.
- Splits a WIDTH-bit add into STAGES equal chunks and adds one chunk per pipeline stage. The carry is registered between stages and the not-yet-used operand bits are carried forward in the registers.
- Full valid/ready handshake on both sides. Sits between operand producers and downstream datapath consumers where a single-cycle wide ripple chain would fail timing.

---
 rtl/pipe_adder_if.sv | 38 +++
 rtl/pipe_adder.sv | 114 +++++++++++
 tb/tb_pipe_adder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The sub select exists only when PIPE_ADDER_SUB_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef PIPE_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: one CHUNK-wide slice per stage, carry registered between stages.
// Optional subtract mode (a - b via a + ~b + 1) is enabled by defining PIPE_ADDER_SUB_EN.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);
  localparam int DIV   = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = (WIDTH / DIV < 1) ? 1 : WIDTH / DIV;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % DIV) != 0) begin : g_param_check
    $error("pipe_adder: WIDTH must be >= 1 and an exact multiple of STAGES");
  end

  logic             valid_q     [STAGES];
  logic             carry_q     [STAGES];
  logic [WIDTH-1:0] res_q       [STAGES];
  logic [WIDTH-1:0] a_q         [STAGES];
  logic [WIDTH-1:0] b_q         [STAGES];
  logic             stage_ready [STAGES+1];
  logic [WIDTH-1:0] b_in;
  logic             carry_in;

  // Subtraction is folded in at the head: B is inverted once and carried down already inverted.
`ifdef PIPE_ADDER_SUB_EN
  assign b_in     = bus.sub ? ~bus.b : bus.b;
  assign carry_in = bus.sub | bus.cin;
`else
  assign b_in     = bus.b;
  assign carry_in = bus.cin;
`endif

  assign stage_ready[STAGES] = bus.out_ready;
  assign bus.in_ready        = stage_ready[0];
  assign bus.out_valid       = valid_q[STAGES-1];
  assign bus.sum             = res_q[STAGES-1];
  assign bus.cout            = carry_q[STAGES-1];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;

    logic             up_valid;
    logic             up_carry;
    logic [WIDTH-1:0] up_res;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_d;

    if (gi == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_carry = carry_in;
      assign up_res   = '0;
      assign a_chunk  = bus.a[LO +: CHUNK];
      assign b_chunk  = b_in[LO +: CHUNK];
    end else begin : g_body
      assign up_valid = valid_q[gi-1];
      assign up_carry = carry_q[gi-1];
      assign up_res   = res_q[gi-1];
      assign a_chunk  = a_q[gi-1][LO +: CHUNK];
      assign b_chunk  = b_q[gi-1][LO +: CHUNK];
    end

    // An empty stage always accepts, so bubbles collapse even while the tail stalls.
    assign stage_ready[gi] = !valid_q[gi] || stage_ready[gi+1];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, up_carry};

    always_comb begin
      res_d              = up_res;
      res_d[LO +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[gi] <= 1'b0;
        carry_q[gi] <= 1'b0;
        res_q[gi]   <= '0;
      end else if (stage_ready[gi]) begin
        valid_q[gi] <= up_valid;
        if (up_valid) begin
          carry_q[gi] <= chunk_sum[CHUNK];
          res_q[gi]   <= res_d;
        end
      end
    end

    // The final stage has no later chunk, so it keeps no operand copy.
    if (gi < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] up_a;
      logic [WIDTH-1:0] up_b;

      if (gi == 0) begin : g_src
        assign up_a = bus.a;
        assign up_b = b_in;
      end else begin : g_src
        assign up_a = a_q[gi-1];
        assign up_b = b_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q[gi] <= '0;
          b_q[gi] <= '0;
        end else if (stage_ready[gi] && up_valid) begin
          a_q[gi] <= up_a;
          b_q[gi] <= up_b;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=8, STAGES=4) with an in-order expected-result queue.
`timescale 1ns/1ps
module tb_pipe_adder;
  localparam int WIDTH  = 8;
  localparam int STAGES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int cycle_no   = 0;
  int n_xfer     = 0;
  int n_acc      = 0;
  int first_xfer = -1;
  int last_xfer  = -1;
  logic           sub_sel = 1'b0;
  logic [WIDTH:0] exp_q [$];

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    sub_sel      = sub;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub      = sub;
`endif
  endtask

  // One clock: observe handshakes at the falling edge, return 1 ns after the rising edge.
  task automatic tick();
    logic [WIDTH:0] e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      n_xfer++;
      if (first_xfer < 0) first_xfer = cycle_no;
      last_xfer = cycle_no;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("out  cyc=%0d sum=%02h cout=%0b exp=%03h", cycle_no, bus.sum, bus.cout, e);
        check("result", 32'({bus.cout, bus.sum}), 32'(e));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a, bus.b, bus.cin, sub_sel));
      n_acc++;
      $display("in   cyc=%0d a=%02h b=%02h cin=%0b sub=%0b", cycle_no, bus.a, bus.b, bus.cin, sub_sel);
    end
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    int edges;
    int idx;
    int acc_before;
    logic [WIDTH-1:0] sa [6];
    logic [WIDTH-1:0] sb [6];
    logic [WIDTH:0]   first_exp;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0xFF + 0x01: full carry ripple, latency STAGES
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check("latency",   32'(edges),    32'(STAGES));
    check("ff01_sum",  32'(bus.sum),  32'h00);
    check("ff01_cout", 32'(bus.cout), 32'd1);
    tick();

    // Carry across chunk boundaries, back to back
    drive(8'h0F, 8'h01, 1'b0, 1'b0);
    tick();
    drive(8'h7F, 8'h00, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    wait_out("carry_timeout");
    check("c1_sum",  32'(bus.sum),  32'h10);
    check("c1_cout", 32'(bus.cout), 32'd0);
    tick();
    check("c2_valid", 32'(bus.out_valid), 32'd1);
    check("c2_sum",   32'(bus.sum),       32'h80);
    check("c2_cout",  32'(bus.cout),      32'd0);
    tick();

    // Stream of 8 random pairs with out_ready high
    n_xfer = 0;
    first_xfer = -1;
    for (int i = 0; i < 8; i++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("stream_count",  32'(n_xfer),                32'd8);
    check("stream_consec", 32'(last_xfer - first_xfer), 32'd7);

    // Backpressure: 6 offered, 4 accepted, first result holds
    for (int i = 0; i < 6; i++) begin
      sa[i] = WIDTH'($urandom);
      sb[i] = WIDTH'($urandom);
    end
    first_exp = model(sa[0], sb[0], 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(sa[idx], sb[idx], 1'b0, 1'b0);
      acc_before = n_acc;
      tick();
      if (n_acc != acc_before) idx++;
    end
    check("stall_accepted", 32'(idx),           32'd4);
    check("stall_in_ready", 32'(bus.in_ready),  32'd0);
    check("stall_valid",    32'(bus.out_valid), 32'd1);
    check("stall_first",    32'({bus.cout, bus.sum}), 32'(first_exp));
    repeat (2) tick();
    check("stall_hold",     32'({bus.cout, bus.sum}), 32'(first_exp));
    bus.out_ready = 1'b1;
    n_xfer = 0;
    for (int c = 0; c < 30 && !(idx == 6 && exp_q.size() == 0); c++) begin
      if (idx < 6) drive(sa[idx], sb[idx], 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      acc_before = n_acc;
      tick();
      if (n_acc != acc_before) idx++;
    end
    bus.in_valid = 1'b0;
    check("drain_accepted", 32'(idx),    32'd6);
    check("drain_count",    32'(n_xfer), 32'd6);

    // Reset mid-flight discards everything
    for (int i = 0; i < 3; i++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    check("mid_rst_sum",      32'(bus.sum),       32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    n_xfer = 0;
    repeat (8) tick();
    check("post_rst_quiet", 32'(n_xfer), 32'd0);

`ifdef PIPE_ADDER_SUB_EN
    // Subtract: 5-7 borrows, 7-5 does not
    drive(8'h05, 8'h07, 1'b0, 1'b1);
    tick();
    drive(8'h07, 8'h05, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_out("sub_timeout");
    check("sub1_sum",  32'(bus.sum),  32'hFE);
    check("sub1_cout", 32'(bus.cout), 32'd0);
    tick();
    check("sub2_sum",  32'(bus.sum),  32'h02);
    check("sub2_cout", 32'(bus.cout), 32'd1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
